// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: one-byte holding register feeding a start/data/parity/stop
// serialiser timed by a 16x oversample enable, with a divisor-update-safe indication.
module uart_tx_sequencer #(
   parameter int OSR    = 16,
   parameter int DATA_W = 8
) (
   input  logic              uart_ref_clk,
   input  logic              rst_n,
   input  logic              baud_tick_16,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [1:0]        cfg_data_len,
   input  logic              cfg_parity_en,
   input  logic              cfg_parity_odd,
   input  logic              cfg_stop2,
   output logic              txd,
   output logic              tx_busy,
   output logic              frame_done,
   output logic              cd_update_ok
);

   localparam int TW = $clog2(OSR);
   localparam logic [TW-1:0] TICK_LAST = TW'(OSR - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // Parity over the 5+len bits actually sent; seeded with 1 for odd parity.
   function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic [1:0] len,
                                      input logic odd);
      logic p;
      p = odd;
      for (int i = 0; i < DATA_W; i++) begin
         p = p ^ (d[i] & ((i < 5 + int'(len)) ? 1'b1 : 1'b0));
      end
      return p;
   endfunction

   state_t            state_q, state_d;
   logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic              stop_cnt_q, stop_cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic [1:0]        len_q, len_d;
   logic              par_en_q, par_en_d;
   logic              par_bit_q, par_bit_d;
   logic              stop2_q, stop2_d;
   logic              txd_q, txd_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;
   logic              cd_ok_q, cd_ok_d;
   logic              bit_end_s;
   logic              load_s;

   assign bit_end_s = baud_tick_16 && (tick_cnt_q == TICK_LAST);

   // Next-state logic for the frame FSM, holding register and registered outputs.
   always_comb begin
      state_d      = state_q;
      tick_cnt_d   = tick_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      stop_cnt_d   = stop_cnt_q;
      shift_d      = shift_q;
      hold_d       = hold_q;
      hold_full_d  = hold_full_q;
      len_d        = len_q;
      par_en_d     = par_en_q;
      par_bit_d    = par_bit_q;
      stop2_d      = stop2_q;
      frame_done_d = 1'b0;
      load_s       = 1'b0;

      if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end else begin
         hold_d      = hold_q;
      end

      if (state_q != S_IDLE && baud_tick_16) begin
         tick_cnt_d = tick_cnt_q + TW'(1);
      end else begin
         tick_cnt_d = tick_cnt_q;
      end

      case (state_q)
         S_IDLE: begin
            load_s = hold_full_q;
         end
         S_START: begin
            if (bit_end_s) begin
               state_d    = S_DATA;
               tick_cnt_d = '0;
               bit_cnt_d  = 3'd0;
            end else begin
               state_d    = S_START;
            end
         end
         S_DATA: begin
            if (bit_end_s) begin
               tick_cnt_d = '0;
               shift_d    = shift_q >> 1;
               if (bit_cnt_q == (3'd4 + {1'b0, len_q})) begin
                  stop_cnt_d = 1'b0;
                  state_d    = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d  = bit_cnt_q + 3'd1;
               end
            end else begin
               state_d = S_DATA;
            end
         end
         S_PARITY: begin
            if (bit_end_s) begin
               state_d    = S_STOP;
               tick_cnt_d = '0;
               stop_cnt_d = 1'b0;
            end else begin
               state_d    = S_PARITY;
            end
         end
         S_STOP: begin
            if (bit_end_s && stop2_q && !stop_cnt_q) begin
               stop_cnt_d = 1'b1;
               tick_cnt_d = '0;
            end else if (bit_end_s) begin
               frame_done_d = 1'b1;
               tick_cnt_d   = '0;
               state_d      = S_IDLE;
               load_s       = hold_full_q;
            end else begin
               state_d      = S_STOP;
            end
         end
         default: begin
            state_d    = S_IDLE;
            tick_cnt_d = '0;
         end
      endcase

      // Loading latches the frame format so later cfg changes only affect the next frame.
      if (load_s) begin
         state_d     = S_START;
         tick_cnt_d  = '0;
         shift_d     = hold_q;
         hold_full_d = 1'b0;
         len_d       = cfg_data_len;
         par_en_d    = cfg_parity_en;
         par_bit_d   = parity_of(hold_q, cfg_data_len, cfg_parity_odd);
         stop2_d     = cfg_stop2;
      end else begin
         len_d       = len_q;
      end

      case (state_q)
         S_IDLE:   txd_d = 1'b1;
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = shift_q[0];
         S_PARITY: txd_d = par_bit_q;
         S_STOP:   txd_d = 1'b1;
         default:  txd_d = 1'b1;
      endcase

      busy_d  = (state_q != S_IDLE);
      cd_ok_d = (state_q == S_IDLE) && !hold_full_q;
   end

   // State and output registers.
   always_ff @(posedge uart_ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         tick_cnt_q   <= '0;
         bit_cnt_q    <= 3'd0;
         stop_cnt_q   <= 1'b0;
         shift_q      <= '0;
         hold_q       <= '0;
         hold_full_q  <= 1'b0;
         len_q        <= 2'd0;
         par_en_q     <= 1'b0;
         par_bit_q    <= 1'b0;
         stop2_q      <= 1'b0;
         txd_q        <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         cd_ok_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         tick_cnt_q   <= tick_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         stop_cnt_q   <= stop_cnt_d;
         shift_q      <= shift_d;
         hold_q       <= hold_d;
         hold_full_q  <= hold_full_d;
         len_q        <= len_d;
         par_en_q     <= par_en_d;
         par_bit_q    <= par_bit_d;
         stop2_q      <= stop2_d;
         txd_q        <= txd_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         cd_ok_q      <= cd_ok_d;
      end
   end

   assign tx_ready     = ~hold_full_q;
   assign txd          = txd_q;
   assign tx_busy      = busy_q;
   assign frame_done   = frame_done_q;
   assign cd_update_ok = cd_ok_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: expected frames are queued when bytes are
// offered and compared bit by bit by a line monitor sampling mid-bit.
module tb_uart_tx_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       baud_tick_16;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [1:0] cfg_data_len;
   logic       cfg_parity_en;
   logic       cfg_parity_odd;
   logic       cfg_stop2;
   logic       txd;
   logic       tx_busy;
   logic       frame_done;
   logic       cd_update_ok;

   typedef struct packed {
      logic [11:0] bits;
      logic [3:0]  nb;
   } frame_t;

   frame_t sb_q[$];
   int     n_chk = 0;
   int     n_pass = 0;
   int     cyc = 0;
   int     fd_cnt = 0;
   int     exp_fd = 0;
   int     cd_high = 0;
   int     start_ticks = 0;
   int     tick_ph = 0;
   bit     mon_en = 1'b0;
   bit     tick_run = 1'b0;
   bit     cnt_ticks = 1'b0;
   bit     cd_watch = 1'b0;
   bit     last_tick = 1'b0;
   logic   mon_prev = 1'b1;

   uart_tx_sequencer #(.OSR(16), .DATA_W(8)) dut (
      .uart_ref_clk   (clk),
      .rst_n          (rst_n),
      .baud_tick_16   (baud_tick_16),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .cfg_data_len   (cfg_data_len),
      .cfg_parity_en  (cfg_parity_en),
      .cfg_parity_odd (cfg_parity_odd),
      .cfg_stop2      (cfg_stop2),
      .txd            (txd),
      .tx_busy        (tx_busy),
      .frame_done     (frame_done),
      .cd_update_ok   (cd_update_ok)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (cd_watch && cd_update_ok) cd_high <= cd_high + 1;
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  tag, obs, obs, exp, exp, cyc);
      end
   endtask

   function automatic frame_t build_frame(input logic [7:0] d, input logic [1:0] len,
                                          input logic pen, input logic podd, input logic stop2);
      frame_t f;
      int     k;
      logic   p;
      f.bits = '0;
      p = podd;
      k = 1;
      for (int i = 0; i < 5 + int'(len); i++) begin
         f.bits[k] = d[i];
         p = p ^ d[i];
         k++;
      end
      if (pen) begin
         f.bits[k] = p;
         k++;
      end
      f.bits[k] = 1'b1;
      k++;
      if (stop2) begin
         f.bits[k] = 1'b1;
         k++;
      end
      f.nb = 4'(k);
      return f;
   endfunction

   // Tick every 4 clocks while running; also counts ticks spent inside a start bit.
   initial begin
      baud_tick_16 = 1'b0;
      forever begin
         @(negedge clk);
         if (last_tick && cnt_ticks && txd == 1'b0) start_ticks++;
         if (tick_run) begin
            if (tick_ph == 3) begin
               baud_tick_16 = 1'b1;
               tick_ph = 0;
            end else begin
               baud_tick_16 = 1'b0;
               tick_ph++;
            end
         end else begin
            baud_tick_16 = 1'b0;
         end
         last_tick = baud_tick_16;
      end
   end

   // Line monitor: on a start edge pop the expected frame and sample each bit mid-way.
   initial begin
      frame_t f;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n && mon_prev && !txd) begin
            check_eq("sb_pending", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
               f = sb_q.pop_front();
               repeat (32) @(negedge clk);
               for (int j = 0; j < int'(f.nb); j++) begin
                  if (j > 0) repeat (64) @(negedge clk);
                  check_eq($sformatf("txd_bit%0d", j), int'(txd), int'(f.bits[j]));
               end
            end
         end
         mon_prev = txd;
      end
   end

   task automatic send(input logic [7:0] d, input bit push);
      int b = 0;
      while (!tx_ready && b < 3000) begin
         @(negedge clk);
         b++;
      end
      check_eq("send_ready", int'(tx_ready), 1);
      tx_data  = d;
      tx_valid = 1'b1;
      if (push) begin
         sb_q.push_back(build_frame(d, cfg_data_len, cfg_parity_en, cfg_parity_odd, cfg_stop2));
         exp_fd++;
      end
      @(negedge clk);
      tx_valid = 1'b0;
      check_eq("ready_low", int'(tx_ready), 0);
   endtask

   task automatic wait_fd(input int budget);
      int b = 0;
      while (fd_cnt < exp_fd && b < budget) begin
         @(negedge clk);
         b++;
      end
      repeat (3) @(negedge clk);
      check_eq("fd_count", fd_cnt, exp_fd);
      check_eq("sb_drained", sb_q.size(), 0);
   endtask

   task automatic wait_line(input logic lvl, input int budget);
      int b = 0;
      while (txd != lvl && b < budget) begin
         @(negedge clk);
         b++;
      end
      check_eq("txd_level_seen", int'(txd), int'(lvl));
   endtask

   task automatic wait_fd_pulse(input int budget);
      int b = 0;
      while (!frame_done && b < budget) begin
         @(negedge clk);
         b++;
      end
      check_eq("fd_pulse_seen", int'(frame_done), 1);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int t_rise;
      int t_fd;
      int gap;
      int lows;
      rst_n          = 1'b0;
      tx_data        = 8'h00;
      tx_valid       = 1'b0;
      cfg_data_len   = 2'd3;
      cfg_parity_en  = 1'b0;
      cfg_parity_odd = 1'b0;
      cfg_stop2      = 1'b0;
      tick_run       = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("rst_txd", int'(txd), 1);
      check_eq("rst_ready", int'(tx_ready), 1);
      check_eq("rst_busy", int'(tx_busy), 0);
      check_eq("rst_fd", int'(frame_done), 0);
      check_eq("rst_cd_ok", int'(cd_update_ok), 1);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      repeat (5) @(negedge clk);

      // 8N1 0xA5: holding register frees one cycle after the load; bit timing exact.
      send(8'hA5, 1'b1);
      @(negedge clk);
      check_eq("ready_back", int'(tx_ready), 1);
      wait_line(1'b0, 50);
      wait_line(1'b1, 200);
      t_rise = cyc;
      wait_fd_pulse(1000);
      t_fd = cyc;
      check_eq("frame_len_clks", t_fd - t_rise, 575);
      @(negedge clk);
      check_eq("fd_one_cycle", int'(frame_done), 0);
      wait_fd(1000);

      // 7-bit, parity, two stop bits: even then odd.
      cfg_data_len  = 2'd2;
      cfg_parity_en = 1'b1;
      cfg_stop2     = 1'b1;
      send(8'h41, 1'b1);
      wait_fd(1500);
      cfg_parity_odd = 1'b1;
      send(8'h41, 1'b1);
      wait_fd(1500);

      // Back-to-back frames; an unaccepted offer while full must not be sent.
      cfg_data_len   = 2'd3;
      cfg_parity_en  = 1'b0;
      cfg_parity_odd = 1'b0;
      cfg_stop2      = 1'b0;
      cd_high        = 0;
      send(8'h55, 1'b1);
      @(negedge clk);
      cd_watch = 1'b1;
      send(8'hFF, 1'b1);
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      lows = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx_ready) lows++;
      end
      tx_valid = 1'b0;
      check_eq("ready_held_low", lows, 0);
      wait_fd_pulse(1000);
      gap = 0;
      while (txd && gap < 10) begin
         @(negedge clk);
         gap++;
      end
      check_eq("b2b_gap", gap, 1);
      @(negedge clk);
      wait_fd_pulse(1000);
      cd_watch = 1'b0;
      wait_fd(1000);
      check_eq("cd_low_b2b", cd_high, 0);

      // Mid-frame length change applies only to the next frame.
      send(8'h3C, 1'b1);
      repeat (200) @(negedge clk);
      cfg_data_len = 2'd0;
      send(8'h1B, 1'b1);
      wait_fd(3000);

      // Reset in the middle of the data bits.
      mon_en       = 1'b0;
      cfg_data_len = 2'd3;
      send(8'hC3, 1'b0);
      wait_line(1'b0, 50);
      repeat (100) @(negedge clk);
      check_eq("busy_pre_rst", int'(tx_busy), 1);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_txd", int'(txd), 1);
      check_eq("midrst_busy", int'(tx_busy), 0);
      check_eq("midrst_ready", int'(tx_ready), 1);
      check_eq("midrst_cd_ok", int'(cd_update_ok), 1);
      @(negedge clk);
      rst_n = 1'b1;
      lows = 0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (!txd) lows++;
      end
      check_eq("post_rst_txd_low", lows, 0);
      check_eq("post_rst_fd", fd_cnt, exp_fd);

      // Ticks withheld for 100 clocks during START: bit holds and still takes 16 ticks.
      start_ticks = 0;
      cnt_ticks   = 1'b1;
      send(8'hFF, 1'b0);
      exp_fd++;
      wait_line(1'b0, 50);
      repeat (5) @(negedge clk);
      tick_run = 1'b0;
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!txd) lows++;
      end
      check_eq("pause_txd_hold", lows, 100);
      tick_run = 1'b1;
      wait_fd(2000);
      cnt_ticks = 1'b0;
      check_eq("start_ticks", start_ticks, 16);
      mon_en = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
- UART transmit controller driven by the 16x oversample enable from the baud generator.
- Accepts bytes from the APB/FIFO side through a valid/ready handshake and holds one byte in a holding register.
- Serialises each frame as start, 5–8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Reports idle windows in which the APB side may safely reprogram the baud divisor.

Parameters:
- OSR, 16: oversample ticks per bit. Legal range 4..32.
- DATA_W, 8: width of tx_data. The frame length is selected at run time by cfg_data_len.

Ports:
- uart_ref_clk  input  1  single clock; all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- baud_tick_16  input  1  oversample enable, 1-cycle pulse, synchronous to uart_ref_clk
- tx_data  input  DATA_W  byte to send; unused upper bits are ignored
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  holding register empty; a transfer occurs when tx_valid && tx_ready
- cfg_data_len  input  2  data bits = 5 + cfg_data_len
- cfg_parity_en  input  1  insert parity bit
- cfg_parity_odd  input  1  1 = odd parity, 0 = even
- cfg_stop2  input  1  1 = two stop bits, 0 = one
- txd  output  1  serial line, idles high
- tx_busy  output  1  FSM not in IDLE
- frame_done  output  1  1-cycle pulse after the last stop bit completes
- cd_update_ok  output  1  high when IDLE and holding register empty; the APB side may change cd/uart_mode_sel only while this is high

Behaviour:
- Reset (asynchronous, rst_n low), applied immediately, mid-frame included:
  - outputs: txd=1, tx_ready=1, tx_busy=0, frame_done=0, cd_update_ok=1
  - state: FSM=IDLE, counters=0, holding register empty
- Holding register:
  - On accept it captures tx_data and becomes full; tx_ready deasserts the next cycle.
  - It empties in the same cycle the FSM loads it into the shift register, so tx_ready rises the following cycle.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - txd=1.
  - If the holding register is full, next clock: load the shift register and go to START.
  - At load, latch data length, parity enable/odd and stop count. Config changes mid-frame have no effect.
- Bit timing:
  - tick_cnt clears on every state entry.
  - On each baud_tick_16, tick_cnt increments.
  - A bit ends on the tick where tick_cnt==OSR-1, so each bit is exactly OSR ticks.
  - Clocks without a tick hold all state.
- START: txd=0; after OSR ticks go to DATA with bit_cnt=0.
- DATA:
  - txd = shift[0]; shift right at each bit end.
  - When bit_cnt reaches 4+cfg_data_len (latched value), go to PARITY if parity is enabled, else STOP.
- PARITY: txd = XOR of the sent data bits, inverted if odd. Lasts one bit time.
- STOP:
  - txd=1 for one bit time, or two if cfg_stop2 was latched.
  - At the final bit end, frame_done pulses for 1 cycle.
  - If the holding register is full, go directly to START with the load in the same cycle (back-to-back frames, no idle gap); otherwise go to IDLE.
- Outputs are registered:
  - txd changes 1 cycle after the qualifying tick/state change.
  - cd_update_ok = (state==IDLE) && holding empty, registered.
- Simultaneous accept and load cannot occur: accept needs the holding register empty, load needs it full.
- A baud_tick_16 in the same cycle as the IDLE→START transition is not counted.
- tx_valid without tx_ready: the data is not captured; the source must hold it.

Test Plan:
- Reset, then tx_data=0xA5, 8N1, tick every 4 clocks:
  - txd bits = 0,1,0,1,0,0,1,0,1,1
  - each bit is 64 clocks; frame_done pulses once about 640 clocks after the load
  - tx_ready is high again 1 cycle after the load.
- cfg_data_len=2 (7 bits), parity enabled, data 0x41:
  - even parity → parity bit 0; odd parity → 1
  - 7E2 frame = 11 bits, with two stop bits high.
- Two bytes 0x55 then 0xFF, with the second offered during the first frame:
  - second START begins the cycle after the first frame's last stop bit; no idle gap
  - two frame_done pulses; cd_update_ok stays low throughout.
- Change cfg_data_len from 3 to 0 mid-frame:
  - current frame still sends 8 data bits; the next frame sends 5.
- Assert rst_n low during DATA:
  - txd=1, tx_busy=0, tx_ready=1 immediately
  - after release, no frame_done and txd stays high with no pending data.
- baud_tick_16 held low for 100 clocks during START:
  - txd and tick_cnt hold their values; the bit resumes and still totals 16 ticks.
